control_unit: RTL

- Hardwired sequencer that sits directly upstream of ALU_System and drives every one of its control inputs.
- Repeats three phases until halted:
  - Fetches a 16-bit instruction as two bytes into IR: low byte from M[PC], high byte from M[PC+1].
  - Decodes opcode and register fields from the IR value fed back by the datapath.
  - Sequences one or two execute cycles, then returns to fetch.
- Holds a registered copy of the ALU flags for conditional branches.

---
 rtl/control_unit_pkg.sv | 106 ++++++++++
 rtl/cu_decoder.sv | 107 ++++++++++
 rtl/control_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the hardwired control unit that drives ALU_System.
package control_unit_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_F0,
    ST_F1,
    ST_EX0,
    ST_EX1,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_BRA = 4'h7;
  localparam logic [3:0] OP_BNE = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hB;
  localparam logic [3:0] OP_LDD = 4'hC;

  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0101;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;

  localparam logic [1:0] MUX_ALU  = 2'b00;
  localparam logic [1:0] MUX_MEM  = 2'b01;
  localparam logic [1:0] MUX_IR   = 2'b10;
  localparam logic [1:0] MUX_ARFC = 2'b11;

  localparam logic [1:0] ARF_AR     = 2'b00;
  localparam logic [1:0] ARF_SP     = 2'b01;
  localparam logic [1:0] ARF_PCPAST = 2'b10;
  localparam logic [1:0] ARF_PC     = 2'b11;

  localparam logic [3:0] ARF_SEL_PC = 4'b1000;
  localparam logic [3:0] ARF_SEL_AR = 4'b0100;

  // Register-file / address-file function codes.
  localparam logic [1:0] FUN_CLEAR = 2'b00;
  localparam logic [1:0] FUN_LOAD  = 2'b01;
  localparam logic [1:0] FUN_DEC   = 2'b10;
  localparam logic [1:0] FUN_INC   = 2'b11;

  localparam logic [1:0] IR_CLEAR = 2'b00;
  localparam logic [1:0] IR_LOAD  = 2'b01;

  typedef struct packed {
    logic [2:0] rf_out_a_sel;
    logic [2:0] rf_out_b_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_r_sel;
    logic [3:0] rf_t_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_funsel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
    logic       halted;
  } ctrl_t;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  // Register-file read select for R1..R4.
  function automatic logic [2:0] rf_sel(input logic [1:0] idx);
    return {1'b1, idx};
  endfunction

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    logic [3:0] code;
    code = ALU_PASS_A;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      default: code = ALU_PASS_A;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational map from (state, IR, registered flags) to the full datapath control bundle.
module cu_decoder
  import control_unit_pkg::*;
#(
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  state_t      state,
  input  logic [15:0] ir,
  input  logic [3:0]  flags_q,
  output ctrl_t       ctrl
);

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;

  assign op = ir[15:12];
  assign rd = ir[11:10];
  assign rs = ir[9:8];

  always_comb begin
    // NOTE: every field gets its inactive value first, so no path through the case can infer a latch.
    ctrl = ctrl_idle();
    unique case (state)
      ST_INIT: begin
        if (CLEAR_ON_START) begin
          ctrl.arf_reg_sel = 4'b1111;
          ctrl.arf_fun_sel = FUN_CLEAR;
          ctrl.rf_r_sel    = 4'b1111;
          ctrl.rf_t_sel    = 4'b1111;
          ctrl.rf_fun_sel  = FUN_CLEAR;
          ctrl.ir_enable   = 1'b1;
          ctrl.ir_funsel   = IR_CLEAR;
        end
      end
      ST_F0, ST_F1: begin
        ctrl.arf_out_d_sel = ARF_PC;
        ctrl.mem_cs        = 1'b0;
        ctrl.ir_enable     = 1'b1;
        ctrl.ir_funsel     = IR_LOAD;
        ctrl.ir_lh         = (state == ST_F1);
        ctrl.arf_reg_sel   = ARF_SEL_PC;
        ctrl.arf_fun_sel   = FUN_INC;
      end
      ST_EX0: begin
        case (op)
          OP_LDI: begin
            ctrl.mux_a_sel  = MUX_IR;
            ctrl.rf_fun_sel = FUN_LOAD;
            ctrl.rf_r_sel   = onehot(rd);
          end
          OP_MOV: begin
            ctrl.rf_out_a_sel = rf_sel(rs);
            ctrl.alu_fun_sel  = ALU_PASS_A;
            ctrl.mux_a_sel    = MUX_ALU;
            ctrl.rf_fun_sel   = FUN_LOAD;
            ctrl.rf_r_sel     = onehot(rd);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl.rf_out_a_sel = rf_sel(rd);
            ctrl.rf_out_b_sel = rf_sel(rs);
            ctrl.alu_fun_sel  = alu_code(op);
            ctrl.mux_a_sel    = MUX_ALU;
            ctrl.rf_fun_sel   = FUN_LOAD;
            ctrl.rf_r_sel     = onehot(rd);
          end
          OP_BRA, OP_BNE: begin
            // BNE tests the Z flag captured by the last ALU instruction.
            if (op == OP_BRA || !flags_q[3]) begin
              ctrl.mux_b_sel   = MUX_IR;
              ctrl.arf_reg_sel = ARF_SEL_PC;
              ctrl.arf_fun_sel = FUN_LOAD;
            end
          end
          OP_INC, OP_DEC: begin
            ctrl.rf_r_sel   = onehot(rd);
            ctrl.rf_fun_sel = (op == OP_INC) ? FUN_INC : FUN_DEC;
          end
          OP_ST, OP_LDD: begin
            ctrl.mux_b_sel   = MUX_IR;
            ctrl.arf_reg_sel = ARF_SEL_AR;
            ctrl.arf_fun_sel = FUN_LOAD;
          end
          default: ;
        endcase
      end
      ST_EX1: begin
        if (op == OP_LDD) begin
          ctrl.arf_out_d_sel = ARF_AR;
          ctrl.mem_cs        = 1'b0;
          ctrl.mux_a_sel     = MUX_MEM;
          ctrl.rf_fun_sel    = FUN_LOAD;
          ctrl.rf_r_sel      = onehot(rd);
        end else if (op == OP_ST) begin
          ctrl.arf_out_d_sel = ARF_AR;
          ctrl.rf_out_a_sel  = rf_sel(rd);
          ctrl.alu_fun_sel   = ALU_PASS_A;
          ctrl.mem_cs        = 1'b0;
          ctrl.mem_wr        = 1'b1;
        end
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer: holds the state and flag registers, decoding lives in cu_decoder.
module control_unit
  import control_unit_pkg::*;
#(
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset_N,
  input  logic [15:0] IR,
  input  logic [3:0]  ALU_Flag,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [3:0]  Flags_Q,
  output logic        Halted
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] flags_q;
  logic [3:0] op;
  logic       flags_load;
  ctrl_t      ctrl_dec;
  ctrl_t      ctrl;

  assign op         = IR[15:12];
  assign flags_load = (state_q == ST_EX0) && (op >= OP_ADD) && (op <= OP_OR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1:   state_d = ST_EX0;
      ST_EX0: begin
        if (op == OP_HLT)                        state_d = ST_HALT;
        else if (op == OP_ST || op == OP_LDD)    state_d = ST_EX1;
        else                                     state_d = ST_F0;
      end
      ST_EX1:  state_d = ST_F0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= ST_INIT;
      flags_q <= 4'b0000;
    end else begin
      // NOTE: registers update with <= so every flop samples pre-edge values regardless of block order.
      state_q <= state_d;
      if (flags_load) flags_q <= ALU_Flag;
    end
  end

  cu_decoder #(
    .CLEAR_ON_START(CLEAR_ON_START)
  ) u_decoder (
    .state   (state_q),
    .ir      (IR),
    .flags_q (flags_q),
    .ctrl    (ctrl_dec)
  );

  // Reset masks the bundle combinationally so a pending store is dropped the instant Reset_N falls.
  assign ctrl = Reset_N ? ctrl_dec : ctrl_idle();

  assign RF_OutASel  = ctrl.rf_out_a_sel;
  assign RF_OutBSel  = ctrl.rf_out_b_sel;
  assign RF_FunSel   = ctrl.rf_fun_sel;
  assign RF_RSel     = ctrl.rf_r_sel;
  assign RF_TSel     = ctrl.rf_t_sel;
  assign ALU_FunSel  = ctrl.alu_fun_sel;
  assign ARF_OutCSel = ctrl.arf_out_c_sel;
  assign ARF_OutDSel = ctrl.arf_out_d_sel;
  assign ARF_FunSel  = ctrl.arf_fun_sel;
  assign ARF_RegSel  = ctrl.arf_reg_sel;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_Enable   = ctrl.ir_enable;
  assign IR_Funsel   = ctrl.ir_funsel;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;
  assign MuxASel     = ctrl.mux_a_sel;
  assign MuxBSel     = ctrl.mux_b_sel;
  assign MuxCSel     = ctrl.mux_c_sel;
  assign Halted      = ctrl.halted;
  assign Flags_Q     = flags_q;

endmodule
